// File: rtl/dht11_pkg.sv
// -----------------------------------------------------------------------------
// dht11_pkg
// Definitions shared by the DHT11 responder and the host-controller bench:
//   - dht_state_e    : responder FSM states
//   - DHT_*          : default protocol timings in 50 MHz clock cycles
//   - CNT_W          : width of the phase/measurement counter
//   - FRAME_BITS     : payload + checksum bits per frame
//   - dht_checksum() : frame checksum, optionally inverted for negative tests
//   - dht_drives_low(): states in which the responder pulls the bus low
// -----------------------------------------------------------------------------
package dht11_pkg;

    localparam int CNT_W      = 21;
    localparam int FRAME_BITS = 40;
    localparam int IDX_W      = 6;

    // Default timings at 50 MHz.
    localparam int DHT_START_MIN   = 800000;  // 16 ms host start pulse
    localparam int DHT_T_WAIT      = 1500;    // 30 us turnaround
    localparam int DHT_T_RESP_LOW  = 4000;    // 80 us
    localparam int DHT_T_RESP_HIGH = 4000;    // 80 us
    localparam int DHT_T_BIT_LOW   = 2500;    // 50 us
    localparam int DHT_T_ZERO_HIGH = 1300;    // 26 us
    localparam int DHT_T_ONE_HIGH  = 3500;    // 70 us
    localparam int DHT_GUARD       = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEAS,
        ST_WAIT_REL,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } dht_state_e;

    // Sum of the four payload bytes, mod 256; inverted when a deliberately
    // bad checksum is requested.
    function automatic logic [7:0] dht_checksum(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3,
        input logic       invert
    );
        logic [7:0] sum;
        sum = b0 + b1 + b2 + b3;
        return invert ? ~sum : sum;
    endfunction

    // Phases in which the responder actively pulls the line low.
    function automatic logic dht_drives_low(input dht_state_e s);
        return (s == ST_RESP_LOW) || (s == ST_BIT_LOW) || (s == ST_END_LOW);
    endfunction

endpackage

// File: rtl/dht11_responder_if.sv
// -----------------------------------------------------------------------------
// dht11_responder_if
// Bundles the responder's bus-side and control/status signals.
//   EN          : block enable (low aborts and releases)
//   DHT_IN      : raw single-wire bus level (asynchronous)
//   DHT_OE      : 1 = pull bus low, 0 = release
//   HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT : payload bytes
//   CRC_INJ     : transmit inverted checksum
//   BUSY        : frame in progress
//   FRAME_DONE  : one-cycle pulse at end of frame
//   COLLISION   : one-cycle pulse when a frame is aborted by a bus conflict
// Modports: master = environment / host side, slave = responder.
// -----------------------------------------------------------------------------
interface dht11_responder_if;

    logic       EN;
    logic       DHT_IN;
    logic       DHT_OE;
    logic [7:0] HUM_INT;
    logic [7:0] HUM_FLOAT;
    logic [7:0] TEMP_INT;
    logic [7:0] TEMP_FLOAT;
    logic       CRC_INJ;
    logic       BUSY;
    logic       FRAME_DONE;
    logic       COLLISION;

    modport master (
        output EN,
        output DHT_IN,
        output HUM_INT,
        output HUM_FLOAT,
        output TEMP_INT,
        output TEMP_FLOAT,
        output CRC_INJ,
        input  DHT_OE,
        input  BUSY,
        input  FRAME_DONE,
        input  COLLISION
    );

    modport slave (
        input  EN,
        input  DHT_IN,
        input  HUM_INT,
        input  HUM_FLOAT,
        input  TEMP_INT,
        input  TEMP_FLOAT,
        input  CRC_INJ,
        output DHT_OE,
        output BUSY,
        output FRAME_DONE,
        output COLLISION
    );

endinterface

// File: rtl/dht11_responder_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for the asynchronous bus level.
//   CLK  : clock
//   RST  : synchronous, active-low reset
//   d_i  : asynchronous input
//   q_o  : synchronized output (two cycles of latency)
// Resets to the idle (pulled-up) bus level so a reset never looks like the
// start of a host pulse.
// -----------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dht11_responder.sv
// -----------------------------------------------------------------------------
// dht11_responder
// DHT11 sensor emulator (responder side of the single-wire protocol).
// Detects a host start pulse, then drives the 80/80 us sync response and a
// 40-bit frame {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CHECKSUM}, MSB first,
// followed by a low end marker. Open-drain: the block only pulls low or
// releases.
// Ports:
//   CLK    : 50 MHz clock
//   RST    : synchronous, active-low reset
//   bus_if : dht11_responder_if.slave (EN, DHT_IN, DHT_OE, payload, CRC_INJ,
//            BUSY, FRAME_DONE, COLLISION)
// All outputs are registered.
// -----------------------------------------------------------------------------
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int START_MIN   = DHT_START_MIN,
    parameter int T_WAIT      = DHT_T_WAIT,
    parameter int T_RESP_LOW  = DHT_T_RESP_LOW,
    parameter int T_RESP_HIGH = DHT_T_RESP_HIGH,
    parameter int T_BIT_LOW   = DHT_T_BIT_LOW,
    parameter int T_ZERO_HIGH = DHT_T_ZERO_HIGH,
    parameter int T_ONE_HIGH  = DHT_T_ONE_HIGH,
    parameter int GUARD       = DHT_GUARD
) (
    input  logic               CLK,
    input  logic               RST,
    dht11_responder_if.slave   bus_if
);

    // Terminal counts: a phase ends when the counter reaches param-1, so the
    // phase lasts exactly param cycles.
    localparam logic [CNT_W-1:0] START_LAST     = CNT_W'(START_MIN - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST      = CNT_W'(T_WAIT - 1);
    localparam logic [CNT_W-1:0] RESP_LOW_LAST  = CNT_W'(T_RESP_LOW - 1);
    localparam logic [CNT_W-1:0] RESP_HIGH_LAST = CNT_W'(T_RESP_HIGH - 1);
    localparam logic [CNT_W-1:0] BIT_LOW_LAST   = CNT_W'(T_BIT_LOW - 1);
    localparam logic [CNT_W-1:0] ZERO_LAST      = CNT_W'(T_ZERO_HIGH - 1);
    localparam logic [CNT_W-1:0] ONE_LAST       = CNT_W'(T_ONE_HIGH - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT      = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(FRAME_BITS - 1);

    logic bus;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d_i (bus_if.DHT_IN),
        .q_o (bus)
    );

    dht_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  coll_q, coll_d;

    logic [CNT_W-1:0]      cnt_sat;
    logic [CNT_W-1:0]      bit_high_last;
    logic                  guard_over;
    logic [7:0]            checksum;

    // Saturating increment: a host holding the line low for a very long time
    // must not wrap the counter back below the start threshold.
    assign cnt_sat       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign bit_high_last = shift_q[FRAME_BITS-1] ? ONE_LAST : ZERO_LAST;
    assign guard_over    = (cnt_q >= GUARD_CNT);
    assign checksum      = dht_checksum(bus_if.HUM_INT, bus_if.HUM_FLOAT,
                                        bus_if.TEMP_INT, bus_if.TEMP_FLOAT,
                                        bus_if.CRC_INJ);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            coll_q  <= coll_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_sat;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        coll_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!bus) begin
                    state_d = ST_MEAS;
                end
            end

            ST_MEAS: begin
                // The IDLE cycle that saw the falling edge is part of the
                // low time, hence the compare against START_MIN-1.
                if (bus) begin
                    cnt_d = '0;
                    if (cnt_q >= START_LAST) begin
                        state_d = ST_WAIT_REL;
                        idx_d   = '0;
                        // Snapshot the payload: input changes after this
                        // point never reach the frame in flight.
                        shift_d = {bus_if.HUM_INT, bus_if.HUM_FLOAT,
                                   bus_if.TEMP_INT, bus_if.TEMP_FLOAT,
                                   checksum};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WAIT_REL: begin
                if (cnt_q >= WAIT_LAST) begin
                    state_d = ST_RESP_LOW;
                    cnt_d   = '0;
                end
            end

            ST_RESP_LOW: begin
                if (cnt_q >= RESP_LOW_LAST) begin
                    state_d = ST_RESP_HIGH;
                    cnt_d   = '0;
                end
            end

            ST_RESP_HIGH: begin
                // The first GUARD cycles still see our own low through the
                // synchronizer, so conflicts are only judged after that.
                if (guard_over && !bus) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    coll_d  = 1'b1;
                end else if (cnt_q >= RESP_HIGH_LAST) begin
                    state_d = ST_BIT_LOW;
                    cnt_d   = '0;
                end
            end

            ST_BIT_LOW: begin
                if (cnt_q >= BIT_LOW_LAST) begin
                    state_d = ST_BIT_HIGH;
                    cnt_d   = '0;
                end
            end

            ST_BIT_HIGH: begin
                if (guard_over && !bus) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    coll_d  = 1'b1;
                end else if (cnt_q >= bit_high_last) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_END_LOW;
                    end else begin
                        state_d = ST_BIT_LOW;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end

            ST_END_LOW: begin
                if (cnt_q >= BIT_LOW_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Disable wins over everything and is silent: no status pulses.
        if (!bus_if.EN) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            coll_d  = 1'b0;
        end

        // Outputs follow the next state so they are registered yet aligned
        // with the state register.
        oe_d   = dht_drives_low(state_d);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_MEAS);
    end

    assign bus_if.DHT_OE     = oe_q;
    assign bus_if.BUSY       = busy_q;
    assign bus_if.FRAME_DONE = done_q;
    assign bus_if.COLLISION  = coll_q;

endmodule

// File: tb/tb_dht11_responder.sv
// -----------------------------------------------------------------------------
// tb_dht11_responder
// Loopback bench: the bus is modelled as an open-drain wire pulled low by
// either the responder (DHT_OE) or the emulated host. Frames are decoded from
// the observed DHT_OE run lengths and compared with the frame expected from
// the payload bytes. Timings are scaled down so a frame is a few hundred
// cycles.
// -----------------------------------------------------------------------------
module tb_dht11_responder;

    localparam int P_START_MIN   = 40;
    localparam int P_T_WAIT      = 6;
    localparam int P_T_RESP_LOW  = 8;
    localparam int P_T_RESP_HIGH = 8;
    localparam int P_T_BIT_LOW   = 5;
    localparam int P_T_ZERO_HIGH = 12;
    localparam int P_T_ONE_HIGH  = 20;
    localparam int P_GUARD       = 4;

    localparam int HOST_LOW      = 60;
    localparam int FRAME_RUNS    = 2 + 2 * 40 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic host_pull = 1'b0;

    int checks = 0;
    int errors = 0;

    dht11_responder_if bus_if ();

    // Open-drain wire with pull-up.
    assign bus_if.DHT_IN = ~(bus_if.DHT_OE | host_pull);

    dht11_responder #(
        .START_MIN   (P_START_MIN),
        .T_WAIT      (P_T_WAIT),
        .T_RESP_LOW  (P_T_RESP_LOW),
        .T_RESP_HIGH (P_T_RESP_HIGH),
        .T_BIT_LOW   (P_T_BIT_LOW),
        .T_ZERO_HIGH (P_T_ZERO_HIGH),
        .T_ONE_HIGH  (P_T_ONE_HIGH),
        .GUARD       (P_GUARD)
    ) dut (
        .CLK    (clk),
        .RST    (rst_n),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the frame is simply the four bytes followed by their
    // byte-sum, complemented when a bad checksum is requested.
    function automatic logic [39:0] ref_frame(input logic [7:0] h, input logic [7:0] hf,
                                              input logic [7:0] t, input logic [7:0] tf,
                                              input bit inj);
        int sum;
        int ck;
        sum = int'(h) + int'(hf) + int'(t) + int'(tf);
        ck  = sum % 256;
        if (inj) ck = 255 - ck;
        return {h, hf, t, tf, 8'(ck)};
    endfunction

    task automatic set_payload(input logic [7:0] h, input logic [7:0] hf,
                               input logic [7:0] t, input logic [7:0] tf, input bit inj);
        bus_if.HUM_INT    = h;
        bus_if.HUM_FLOAT  = hf;
        bus_if.TEMP_INT   = t;
        bus_if.TEMP_FLOAT = tf;
        bus_if.CRC_INJ    = inj;
    endtask

    task automatic host_start(input int low_cycles);
        host_pull = 1'b1;
        repeat (low_cycles) @(negedge clk);
        host_pull = 1'b0;
    endtask

    // Samples until DHT_OE is seen high; n = samples taken (bounded).
    task automatic wait_oe_high(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.DHT_OE !== 1'b1 && n < 500);
    endtask

    // Waits for the given number of DHT_OE 1->0 transitions.
    task automatic wait_falls(input int nfalls, output bit ok);
        logic prev;
        int   falls;
        int   n;
        prev  = bus_if.DHT_OE;
        falls = 0;
        n     = 0;
        while (falls < nfalls && n < 3000) begin
            @(negedge clk);
            n++;
            if (prev === 1'b1 && bus_if.DHT_OE === 1'b0) falls++;
            prev = bus_if.DHT_OE;
        end
        ok = (falls == nfalls);
    endtask

    // Issues a valid start, decodes the whole frame from the DHT_OE waveform
    // and checks it against the reference.
    task automatic run_frame(input logic [7:0] h, input logic [7:0] hf,
                             input logic [7:0] t, input logic [7:0] tf,
                             input bit inj, input bit scramble, input string tag);
        logic [39:0] expv;
        logic [39:0] got;
        int          runs[$];
        int          lat;
        logic        cur;
        int          run;
        int          n;
        int          done_cnt;
        int          coll_cnt;
        int          bad_low;
        int          bad_high;
        logic        busy_at_done;

        set_payload(h, hf, t, tf, inj);
        expv = ref_frame(h, hf, t, tf, inj);
        host_start(HOST_LOW);
        wait_oe_high(lat);
        check({tag, "_latency"}, 64'(lat), 64'(P_T_WAIT + 3));
        check({tag, "_busy_in_frame"}, 64'(bus_if.BUSY), 64'(1));

        // The frame is already latched; these changes must not leak in.
        if (scramble) begin
            set_payload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                        bit'($urandom_range(0, 1)));
        end

        cur          = 1'b1;
        run          = 1;
        n            = 0;
        done_cnt     = 0;
        coll_cnt     = 0;
        busy_at_done = 1'b1;
        while (n < 5000) begin
            @(negedge clk);
            n++;
            if (bus_if.COLLISION === 1'b1) coll_cnt++;
            if (bus_if.DHT_OE === cur) begin
                run++;
            end else begin
                runs.push_back(run);
                cur = bus_if.DHT_OE;
                run = 1;
            end
            if (bus_if.FRAME_DONE === 1'b1) begin
                done_cnt++;
                busy_at_done = bus_if.BUSY;
                break;
            end
            if (coll_cnt != 0) break;
        end

        check({tag, "_frame_done"}, 64'(done_cnt), 64'(1));
        check({tag, "_no_collision"}, 64'(coll_cnt), 64'(0));
        check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'(0));
        check({tag, "_run_count"}, 64'(runs.size()), 64'(FRAME_RUNS));

        if (runs.size() == FRAME_RUNS) begin
            check({tag, "_resp_low"}, 64'(runs[0]), 64'(P_T_RESP_LOW));
            check({tag, "_resp_high"}, 64'(runs[1]), 64'(P_T_RESP_HIGH));
            got      = '0;
            bad_low  = 0;
            bad_high = 0;
            for (int i = 0; i < 40; i++) begin
                if (runs[2 + 2 * i] != P_T_BIT_LOW) bad_low++;
                if (runs[3 + 2 * i] != P_T_ZERO_HIGH && runs[3 + 2 * i] != P_T_ONE_HIGH)
                    bad_high++;
                got = {got[38:0], (runs[3 + 2 * i] == P_T_ONE_HIGH)};
            end
            check({tag, "_bit_low_lengths"}, 64'(bad_low), 64'(0));
            check({tag, "_bit_high_lengths"}, 64'(bad_high), 64'(0));
            check({tag, "_end_low"}, 64'(runs[FRAME_RUNS - 1]), 64'(P_T_BIT_LOW));
            check({tag, "_frame_bits"}, 64'(got), 64'(expv));
        end

        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(bus_if.FRAME_DONE), 64'(0));
        check({tag, "_busy_after"}, 64'(bus_if.BUSY), 64'(0));
        $display("frame %s: expected=0x%010h decoded=0x%010h", tag, expv, got);
    endtask

    // Watches the outputs for a while; counts any activity.
    task automatic watch_quiet(input int cycles, output int oe_hi, output int busy_hi,
                               output int done_hi, output int coll_hi);
        oe_hi   = 0;
        busy_hi = 0;
        done_hi = 0;
        coll_hi = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus_if.DHT_OE !== 1'b0) oe_hi++;
            if (bus_if.BUSY !== 1'b0) busy_hi++;
            if (bus_if.FRAME_DONE !== 1'b0) done_hi++;
            if (bus_if.COLLISION !== 1'b0) coll_hi++;
        end
    endtask

    initial begin
        int   lat;
        bit   ok;
        int   oe_hi, busy_hi, done_hi, coll_hi;
        int   coll_cnt;
        logic oe_at, busy_at;

        bus_if.EN = 1'b1;
        set_payload(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_oe", 64'(bus_if.DHT_OE), 64'(0));
        check("reset_busy", 64'(bus_if.BUSY), 64'(0));
        check("reset_done", 64'(bus_if.FRAME_DONE), 64'(0));
        check("reset_coll", 64'(bus_if.COLLISION), 64'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Directed payload, good checksum, then deliberately bad checksum.
        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 1'b0, "t1_basic");
        repeat (20) @(negedge clk);
        run_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b1, 1'b0, "t2_crc_inj");
        repeat (20) @(negedge clk);

        // Short host pulse: must be ignored.
        host_start(10);
        watch_quiet(200, oe_hi, busy_hi, done_hi, coll_hi);
        check("short_pulse_oe", 64'(oe_hi), 64'(0));
        check("short_pulse_busy", 64'(busy_hi), 64'(0));
        $display("short pulse: oe_cycles=%0d busy_cycles=%0d", oe_hi, busy_hi);

        // Randomized payloads; inputs scrambled mid-frame.
        for (int k = 0; k < 3; k++) begin
            run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      bit'($urandom_range(0, 1)), 1'b1, $sformatf("t3_rand%0d", k));
            repeat (20) @(negedge clk);
        end

        // Collision during the high phase of bit 5 (6th bit).
        set_payload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        host_start(HOST_LOW);
        wait_falls(7, ok);
        check("coll_reach_bit5", 64'(ok), 64'(1));
        repeat (4) @(negedge clk);
        host_pull = 1'b1;
        coll_cnt  = 0;
        oe_at     = 1'b1;
        busy_at   = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.COLLISION === 1'b1) begin
                coll_cnt++;
                oe_at   = bus_if.DHT_OE;
                busy_at = bus_if.BUSY;
            end
        end
        host_pull = 1'b0;
        check("coll_pulse_count", 64'(coll_cnt), 64'(1));
        check("coll_oe_released", 64'(oe_at), 64'(0));
        check("coll_busy_low", 64'(busy_at), 64'(0));
        watch_quiet(100, oe_hi, busy_hi, done_hi, coll_hi);
        check("coll_after_oe", 64'(oe_hi), 64'(0));
        check("coll_after_done", 64'(done_hi), 64'(0));
        $display("collision: pulses=%0d oe_after=%0d done_after=%0d", coll_cnt, oe_hi, done_hi);

        // EN dropped during the response low phase.
        host_start(HOST_LOW);
        wait_oe_high(lat);
        check("en_reach_resp_low", 64'(bus_if.DHT_OE), 64'(1));
        repeat (2) @(negedge clk);
        bus_if.EN = 1'b0;
        @(negedge clk);
        check("en_abort_oe", 64'(bus_if.DHT_OE), 64'(0));
        check("en_abort_busy", 64'(bus_if.BUSY), 64'(0));
        watch_quiet(30, oe_hi, busy_hi, done_hi, coll_hi);
        check("en_abort_no_done", 64'(done_hi), 64'(0));
        check("en_abort_no_coll", 64'(coll_hi), 64'(0));
        $display("en abort: oe_after=%0d done_after=%0d", oe_hi, done_hi);
        bus_if.EN = 1'b1;
        repeat (5) @(negedge clk);
        run_frame(8'h41, 8'h00, 8'h1C, 8'h00, 1'b0, 1'b0, "t4_after_en");
        repeat (20) @(negedge clk);

        // Reset during bit 20.
        host_start(HOST_LOW);
        wait_falls(22, ok);
        check("rst_reach_bit20", 64'(ok), 64'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_abort_oe", 64'(bus_if.DHT_OE), 64'(0));
        check("rst_abort_busy", 64'(bus_if.BUSY), 64'(0));
        rst_n = 1'b1;
        watch_quiet(30, oe_hi, busy_hi, done_hi, coll_hi);
        check("rst_abort_no_done", 64'(done_hi), 64'(0));
        $display("reset abort: oe_after=%0d done_after=%0d", oe_hi, done_hi);
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1,
                  "t5_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
